// File: rtl/id_ex_reg.sv
// id_ex_reg: decode-to-execute pipeline register with valid/ready handshake,
// stall, flush, x0 forcing and optional writeback bypass (ID_EX_WB_BYPASS_EN).
// Ports:
//   clk, rst (sync, active-high)
//   id_*  : decode payload in, id_valid_i / id_ready_o handshake
//   wb_*  : writeback port (bypass source)
//   ex_*  : registered payload out, ex_valid_o / ex_ready_i handshake
//   flush_i kills the held entry and blocks the incoming one
module id_ex_reg #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int CTRL_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  id_valid_i,
   output logic                  id_ready_o,
   input  logic [DATA_WIDTH-1:0] id_pc_i,
   input  logic [DATA_WIDTH-1:0] id_imm_i,
   input  logic [ADDR_WIDTH-1:0] id_rs1_addr_i,
   input  logic [ADDR_WIDTH-1:0] id_rs2_addr_i,
   input  logic [ADDR_WIDTH-1:0] id_rd_addr_i,
   input  logic [DATA_WIDTH-1:0] id_rs1_data_i,
   input  logic [DATA_WIDTH-1:0] id_rs2_data_i,
   input  logic [CTRL_WIDTH-1:0] id_ctrl_i,
   input  logic                  flush_i,
   input  logic                  wb_we_i,
   input  logic [ADDR_WIDTH-1:0] wb_addr_i,
   input  logic [DATA_WIDTH-1:0] wb_data_i,
   output logic                  ex_valid_o,
   input  logic                  ex_ready_i,
   output logic [DATA_WIDTH-1:0] ex_pc_o,
   output logic [DATA_WIDTH-1:0] ex_imm_o,
   output logic [DATA_WIDTH-1:0] ex_rs1_data_o,
   output logic [DATA_WIDTH-1:0] ex_rs2_data_o,
   output logic [ADDR_WIDTH-1:0] ex_rs1_addr_o,
   output logic [ADDR_WIDTH-1:0] ex_rs2_addr_o,
   output logic [ADDR_WIDTH-1:0] ex_rd_addr_o,
   output logic [CTRL_WIDTH-1:0] ex_ctrl_o
);

   logic                  accept;
   logic                  consume;
   logic                  stall;
   logic [DATA_WIDTH-1:0] rs1_cap;
   logic [DATA_WIDTH-1:0] rs2_cap;
   logic [DATA_WIDTH-1:0] rs1_upd;
   logic [DATA_WIDTH-1:0] rs2_upd;

   // Only combinational path: ex_ready_i -> id_ready_o.
   assign id_ready_o = !rst && !flush_i && (!ex_valid_o || ex_ready_i);
   assign accept     = id_valid_i && id_ready_o;
   assign consume    = ex_valid_o && ex_ready_i;
   assign stall      = ex_valid_o && !ex_ready_i;

`ifdef ID_EX_WB_BYPASS_EN
   logic wb_live;

   // A write to x0 never forwards.
   assign wb_live = wb_we_i && (wb_addr_i != '0);

   always_comb begin
      rs1_cap = id_rs1_data_i;
      rs2_cap = id_rs2_data_i;
      rs1_upd = ex_rs1_data_o;
      rs2_upd = ex_rs2_data_o;
      if (wb_live && (wb_addr_i == id_rs1_addr_i)) rs1_cap = wb_data_i;
      if (wb_live && (wb_addr_i == id_rs2_addr_i)) rs2_cap = wb_data_i;
      if (id_rs1_addr_i == '0) rs1_cap = '0;
      if (id_rs2_addr_i == '0) rs2_cap = '0;
      // Held address is nonzero whenever it matches a live write.
      if (wb_live && (wb_addr_i == ex_rs1_addr_o)) rs1_upd = wb_data_i;
      if (wb_live && (wb_addr_i == ex_rs2_addr_o)) rs2_upd = wb_data_i;
   end
`else
   logic unused_wb;

   assign unused_wb = ^{wb_we_i, wb_addr_i, wb_data_i};

   always_comb begin
      rs1_cap = (id_rs1_addr_i == '0) ? '0 : id_rs1_data_i;
      rs2_cap = (id_rs2_addr_i == '0) ? '0 : id_rs2_data_i;
      rs1_upd = ex_rs1_data_o;
      rs2_upd = ex_rs2_data_o;
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_valid_o    <= 1'b0;
         ex_pc_o       <= '0;
         ex_imm_o      <= '0;
         ex_rs1_data_o <= '0;
         ex_rs2_data_o <= '0;
         ex_rs1_addr_o <= '0;
         ex_rs2_addr_o <= '0;
         ex_rd_addr_o  <= '0;
         ex_ctrl_o     <= '0;
      end else if (flush_i) begin
         // Clearing ctrl guarantees no side effect leaks from a killed entry.
         ex_valid_o <= 1'b0;
         ex_ctrl_o  <= '0;
      end else if (accept) begin
         ex_valid_o    <= 1'b1;
         ex_pc_o       <= id_pc_i;
         ex_imm_o      <= id_imm_i;
         ex_rs1_data_o <= rs1_cap;
         ex_rs2_data_o <= rs2_cap;
         ex_rs1_addr_o <= id_rs1_addr_i;
         ex_rs2_addr_o <= id_rs2_addr_i;
         ex_rd_addr_o  <= id_rd_addr_i;
         ex_ctrl_o     <= id_ctrl_i;
      end else begin
         if (consume) ex_valid_o <= 1'b0;
         if (stall) begin
            ex_rs1_data_o <= rs1_upd;
            ex_rs2_data_o <= rs2_upd;
         end
      end
   end

endmodule

// File: tb/tb_id_ex_reg.sv
// tb_id_ex_reg: scoreboard bench for id_ex_reg, register-file reference model,
// directed test-plan cases followed by randomized traffic.
module tb_id_ex_reg;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        id_valid_i = 1'b0;
   logic        id_ready_o;
   logic [31:0] id_pc_i = '0;
   logic [31:0] id_imm_i = '0;
   logic [4:0]  id_rs1_addr_i = '0;
   logic [4:0]  id_rs2_addr_i = '0;
   logic [4:0]  id_rd_addr_i = '0;
   logic [31:0] id_rs1_data_i = '0;
   logic [31:0] id_rs2_data_i = '0;
   logic [15:0] id_ctrl_i = '0;
   logic        flush_i = 1'b0;
   logic        wb_we_i = 1'b0;
   logic [4:0]  wb_addr_i = '0;
   logic [31:0] wb_data_i = '0;
   logic        ex_valid_o;
   logic        ex_ready_i = 1'b0;
   logic [31:0] ex_pc_o;
   logic [31:0] ex_imm_o;
   logic [31:0] ex_rs1_data_o;
   logic [31:0] ex_rs2_data_o;
   logic [4:0]  ex_rs1_addr_o;
   logic [4:0]  ex_rs2_addr_o;
   logic [4:0]  ex_rd_addr_o;
   logic [15:0] ex_ctrl_o;

   id_ex_reg dut (
      .clk           (clk),
      .rst           (rst),
      .id_valid_i    (id_valid_i),
      .id_ready_o    (id_ready_o),
      .id_pc_i       (id_pc_i),
      .id_imm_i      (id_imm_i),
      .id_rs1_addr_i (id_rs1_addr_i),
      .id_rs2_addr_i (id_rs2_addr_i),
      .id_rd_addr_i  (id_rd_addr_i),
      .id_rs1_data_i (id_rs1_data_i),
      .id_rs2_data_i (id_rs2_data_i),
      .id_ctrl_i     (id_ctrl_i),
      .flush_i       (flush_i),
      .wb_we_i       (wb_we_i),
      .wb_addr_i     (wb_addr_i),
      .wb_data_i     (wb_data_i),
      .ex_valid_o    (ex_valid_o),
      .ex_ready_i    (ex_ready_i),
      .ex_pc_o       (ex_pc_o),
      .ex_imm_o      (ex_imm_o),
      .ex_rs1_data_o (ex_rs1_data_o),
      .ex_rs2_data_o (ex_rs2_data_o),
      .ex_rs1_addr_o (ex_rs1_addr_o),
      .ex_rs2_addr_o (ex_rs2_addr_o),
      .ex_rd_addr_o  (ex_rd_addr_o),
      .ex_ctrl_o     (ex_ctrl_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] imm;
      logic [31:0] d1;
      logic [31:0] d2;
      logic [4:0]  a1;
      logic [4:0]  a2;
      logic [4:0]  rd;
      logic [15:0] ctrl;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] rf[32];
   bit          m_full = 1'b0;
   bit          m_ctrl_clr = 1'b1;
   bit          m_pay_zero = 1'b1;
   int          n_cmp = 0;
   int          n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Drive one cycle of inputs; register-file read data comes from the model.
   task automatic drive(input bit r, input bit v, input logic [31:0] pc,
                        input logic [4:0] a1, input logic [4:0] a2,
                        input bit rdy, input bit fl, input bit we,
                        input logic [4:0] wa, input logic [31:0] wd);
      @(posedge clk);
      #1;
      rst           = r;
      id_valid_i    = v;
      id_pc_i       = pc;
      id_imm_i      = $urandom;
      id_rs1_addr_i = a1;
      id_rs2_addr_i = a2;
      id_rd_addr_i  = 5'($urandom_range(0, 31));
      id_rs1_data_i = (a1 == 5'd0) ? ($urandom | 32'h1) : rf[a1];
      id_rs2_data_i = (a2 == 5'd0) ? ($urandom | 32'h1) : rf[a2];
      id_ctrl_i     = 16'($urandom_range(1, 65535));
      ex_ready_i    = rdy;
      flush_i       = fl;
      wb_we_i       = we;
      wb_addr_i     = wa;
      wb_data_i     = wd;
   endtask

   // Reference model: evaluates what the coming edge does.
   initial begin
      for (int i = 0; i < 32; i++) rf[i] = '0;
      @(posedge clk);
      forever begin
         @(negedge clk);
         #1;
         if (rst) begin
            sb.delete();
            m_full     = 1'b0;
            m_ctrl_clr = 1'b1;
            m_pay_zero = 1'b1;
         end else if (flush_i) begin
            sb.delete();
            m_full     = 1'b0;
            m_ctrl_clr = 1'b1;
         end else if (id_valid_i && (!m_full || ex_ready_i)) begin
            exp_t e;
            e.pc   = id_pc_i;
            e.imm  = id_imm_i;
            e.a1   = id_rs1_addr_i;
            e.a2   = id_rs2_addr_i;
            e.rd   = id_rd_addr_i;
            e.ctrl = id_ctrl_i;
            e.d1   = rf[id_rs1_addr_i];
            e.d2   = rf[id_rs2_addr_i];
            sb.push_back(e);
            m_full     = 1'b1;
            m_ctrl_clr = 1'b0;
            m_pay_zero = 1'b0;
         end else if (m_full && ex_ready_i) begin
            m_full = 1'b0;
         end
         if (wb_we_i && (wb_addr_i != 5'd0)) rf[wb_addr_i] = wb_data_i;
      end
   end

   // Monitor: checks handshake state each cycle, pops on every consume.
   initial begin
      @(posedge clk);
      forever begin
         @(negedge clk);
         chk("id_ready", 32'(id_ready_o),
             32'(!rst && !flush_i && (!m_full || ex_ready_i)));
         chk("ex_valid", 32'(ex_valid_o), 32'(m_full));
         if (!m_full && m_ctrl_clr) chk("ctrl_clear", 32'(ex_ctrl_o), 32'd0);
         if (!m_full && m_pay_zero) begin
            chk("pc_reset", ex_pc_o, 32'd0);
            chk("rs1_reset", ex_rs1_data_o, 32'd0);
            chk("rs2_reset", ex_rs2_data_o, 32'd0);
         end
         if (ex_valid_o && ex_ready_i && !flush_i && !rst) begin
            if (sb.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL sb_pop: got pc %h expected no instruction",
                        ex_pc_o);
            end else begin
               exp_t e;
               logic [31:0] x1;
               logic [31:0] x2;
               e = sb.pop_front();
`ifdef ID_EX_WB_BYPASS_EN
               x1 = rf[e.a1];
               x2 = rf[e.a2];
`else
               x1 = e.d1;
               x2 = e.d2;
`endif
               chk("pc", ex_pc_o, e.pc);
               chk("imm", ex_imm_o, e.imm);
               chk("addrs", 32'({ex_rs1_addr_o, ex_rs2_addr_o, ex_rd_addr_o}),
                   32'({e.a1, e.a2, e.rd}));
               chk("ctrl", 32'(ex_ctrl_o), 32'(e.ctrl));
               chk("rs1_data", ex_rs1_data_o, x1);
               chk("rs2_data", ex_rs2_data_o, x2);
            end
         end
      end
   end

   initial begin
      // Reset then stream of three
      drive(1, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0);
      drive(1, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0);
      drive(0, 1, 32'h00, 1, 2, 1, 0, 0, 0, 0);
      drive(0, 1, 32'h04, 3, 0, 1, 0, 0, 0, 0);
      drive(0, 1, 32'h08, 2, 1, 1, 0, 0, 0, 0);
      drive(0, 0, 32'h0, 0, 0, 1, 0, 0, 0, 0);
      // Stall
      drive(0, 1, 32'h10, 3, 4, 1, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) drive(0, 1, 32'h14, 3, 4, 0, 0, 0, 0, 0);
      drive(0, 1, 32'h14, 3, 4, 1, 0, 0, 0, 0);
      drive(0, 0, 32'h0, 0, 0, 1, 0, 0, 0, 0);
      // Flush while full and stalled
      drive(0, 1, 32'h18, 1, 2, 1, 0, 0, 0, 0);
      drive(0, 1, 32'h20, 1, 2, 0, 1, 0, 0, 0);
      drive(0, 0, 32'h0, 0, 0, 1, 0, 0, 0, 0);
      // Capture bypass; rs2 = x0 forcing
      drive(0, 0, 32'h0, 0, 0, 1, 0, 1, 5, 32'h1111);
      drive(0, 1, 32'h30, 5, 0, 0, 0, 1, 5, 32'hABCD);
      drive(0, 0, 32'h0, 0, 0, 1, 0, 0, 0, 0);
      // Stall bypass, x0 write ignored
      drive(0, 0, 32'h0, 0, 0, 1, 0, 1, 7, 32'h0);
      drive(0, 1, 32'h40, 0, 7, 0, 0, 0, 0, 0);
      drive(0, 0, 32'h0, 0, 0, 0, 0, 1, 7, 32'h55);
      drive(0, 0, 32'h0, 0, 0, 0, 0, 1, 0, 32'h99);
      drive(0, 0, 32'h0, 0, 0, 1, 0, 0, 0, 0);
      // Randomized traffic
      for (int i = 0; i < 800; i++) begin
         drive(($urandom_range(0, 99) < 2),
               ($urandom_range(0, 99) < 70),
               $urandom,
               5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)),
               ($urandom_range(0, 99) < 60),
               ($urandom_range(0, 99) < 8),
               ($urandom_range(0, 99) < 50),
               5'($urandom_range(0, 7)),
               $urandom);
      end
      for (int i = 0; i < 3; i++) drive(0, 0, 32'h0, 0, 0, 1, 0, 0, 0, 0);
      @(negedge clk);
      #2;
      chk("sb_drain", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/id_ex_reg.md
# id_ex_reg

Pipeline register between the decode stage and the execute stage, holding one decoded instruction: PC, immediate, register addresses, both source operands and an opaque control bundle. Upstream it takes the decode outputs, including the operand values read combinationally from the register file. It hands them to execute with a valid/ready handshake, and supports stall, flush and, optionally, writeback-to-operand bypass. The bypass covers the register file's missing write-before-read forwarding and refreshes operands while an instruction is stalled.

## Interface
- DATA_WIDTH, 32, width of PC, immediate and operand data
- ADDR_WIDTH, 5, register address width
- CTRL_WIDTH, 16, width of the opaque execute control bundle
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- id_valid_i  in  1  decode holds a valid instruction
- id_ready_o  out  1  block can accept this cycle
- id_pc_i, id_imm_i  in  DATA_WIDTH  instruction PC and sign-extended immediate
- id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i  in  ADDR_WIDTH  source and destination register indices
- id_rs1_data_i, id_rs2_data_i  in  DATA_WIDTH  register file read data
- id_ctrl_i  in  CTRL_WIDTH  control bundle (ALU op, mem op, wb enable, ...)
- flush_i  in  1  kill the held instruction and drop the incoming one
- wb_we_i  in  1  writeback write enable (same signal driving the register file)
- wb_addr_i  in  ADDR_WIDTH  writeback destination
- wb_data_i  in  DATA_WIDTH  writeback data
- ex_valid_o  out  1  held instruction is valid
- ex_ready_i  in  1  execute consumes the instruction this cycle
- ex_pc_o, ex_imm_o, ex_rs1_data_o, ex_rs2_data_o  out  DATA_WIDTH  registered payload
- ex_rs1_addr_o, ex_rs2_addr_o, ex_rd_addr_o  out  ADDR_WIDTH  registered payload
- ex_ctrl_o  out  CTRL_WIDTH  registered control bundle

## Operation
- Single-entry register with one state bit, ex_valid_o: EMPTY (0) or FULL (1).
- id_ready_o = !rst && !flush_i && (!ex_valid_o || ex_ready_i). It forms the only combinational path: ex_ready_i to id_ready_o.
- Accept: id_valid_i && id_ready_o.
  - Capture all id_* payload.
  - Next ex_valid_o = 1.
- Consume without accept: ex_valid_o && ex_ready_i && !accept.
  - Next ex_valid_o = 0.
  - Payload holds its value.
- Consume and accept in the same cycle: new payload loads and ex_valid_o stays 1, giving back-to-back throughput of 1 per cycle.
- Stall: ex_valid_o && !ex_ready_i. Payload holds, except for the in-place bypass update below.
- Flush has priority over everything except rst.
  - Next ex_valid_o = 0 and ex_ctrl_o = 0.
  - The incoming instruction is dropped, because id_ready_o = 0.
  - Other payload fields hold.
- x0 rule: any captured or updated operand whose address is 0 is stored as 0, regardless of id_rs*_data_i or wb_data_i.
- Reset: every output register goes to 0, so ex_valid_o = 0 and ex_ctrl_o = 0. id_ready_o = 0 while rst = 1.

## Timing
- Latency is 1 cycle: an instruction accepted on edge N is presented on ex_* immediately after edge N.
- A flush asserted in cycle N gives ex_valid_o = 0 after edge N, whether or not ex_ready_i is high.
- Reset asserted in the middle of a stall behaves like a flush, with all payload also cleared.
- The bypass compare uses wb_* values sampled at the same edge as the capture or stall update. No additional cycles.

## Configuration
- Macro ID_EX_WB_BYPASS_EN.
- When defined, the bypass is active.
  - On accept: if wb_we_i, wb_addr_i != 0 and wb_addr_i == id_rsK_addr_i, capture wb_data_i instead of id_rsK_data_i (K = 1, 2, independently).
  - While FULL and not consumed and not flushed: if wb_we_i, wb_addr_i != 0 and wb_addr_i == ex_rsK_addr_o, overwrite ex_rsK_data_o with wb_data_i.
  - Consumed and flushed entries are never updated.
- When undefined, operands are exactly the captured register file read data, with the x0 rule still applied. wb_* inputs are unused.

## Test plan
- Reset then stream: rst high 2 cycles, giving ex_valid_o = 0, id_ready_o = 0 and ex_ctrl_o = 0. Then 3 back-to-back instructions with PC 0x00/0x04/0x08 and ex_ready_i = 1 → ex_pc_o shows 0x00, 0x04, 0x08 on consecutive cycles with ex_valid_o held at 1.
- Stall: accept PC 0x10, then hold ex_ready_i = 0 for 3 cycles → id_ready_o = 0, ex_pc_o stays 0x10, and the next instruction (PC 0x14) enters only on the cycle ex_ready_i returns to 1.
- Flush while FULL and stalled, with id_valid_i = 1 (PC 0x20) → ex_valid_o = 0 and ex_ctrl_o = 0 next cycle, and PC 0x20 never appears.
- Capture bypass (macro on): accept with rs1 = 5 and id_rs1_data_i = 0x1111 while wb_we_i = 1, wb_addr_i = 5, wb_data_i = 0xABCD → ex_rs1_data_o = 0xABCD. With the macro off → 0x1111.
- Stall bypass (macro on): FULL with rs2 = 7 and ex_rs2_data_o = 0x0, stalled; WB writes 0x55 to x7 → ex_rs2_data_o = 0x55 next cycle. A WB write to x0 with 0x99 leaves an x0 operand at 0.
- x0 forcing: accept rs1 = 0 with id_rs1_data_i = 0xDEAD → ex_rs1_data_o = 0.
